// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and filters the user_io PS/2 lines, deserialises
// 11-bit frames and folds E0/F0/E1 prefix sequences into single key events.
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_strobe,
  output logic       frame_error
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk, fall, flip;
  logic [3:0]    filt_cnt;
  state_t        state, next_state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par, good, bad, tout, byte_valid;
  logic [TW-1:0] tcnt;
  logic          ext_f, rel_f;
  logic [2:0]    skip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample;
  // fall is high in the first cycle the filtered clock reads low.
  assign flip = (clk_s2 != filt_clk) && (filt_cnt == 4'(FILTER_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= 4'd0;
      fall     <= 1'b0;
    end else begin
      fall <= flip && filt_clk;
      if (flip) begin
        filt_clk <= clk_s2;
        filt_cnt <= 4'd0;
      end else if (clk_s2 != filt_clk) begin
        filt_cnt <= filt_cnt + 4'd1;
      end else begin
        filt_cnt <= 4'd0;
      end
    end
  end

  always_comb begin
    next_state = state;
    good       = 1'b0;
    bad        = 1'b0;
    tout       = 1'b0;
    case (state)
      IDLE:    if (fall && !data_s2) next_state = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) next_state = PARITY;
      PARITY:  if (fall) next_state = STOP;
      STOP: begin
        if (fall) begin
          next_state = IDLE;
          if (data_s2 && par) good = 1'b1;
          else                bad  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    // An edge in the same cycle beats the timeout.
    if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      tout       = 1'b1;
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      par         <= 1'b0;
      tcnt        <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= next_state;
      byte_valid  <= good;
      frame_error <= bad | tout;
      if (state == IDLE || fall || tout) tcnt <= '0;
      else                               tcnt <= tcnt + TW'(1);
      if (fall) begin
        case (state)
          IDLE: begin
            bit_cnt <= 3'd0;
            par     <= 1'b0;
          end
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            par     <= par ^ data_s2;
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par <= par ^ data_s2;
          default: ;
        endcase
      end
    end
  end

  // Prefix folding; during a Pause sequence every byte is swallowed uninterpreted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code     <= 8'd0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      key_strobe   <= 1'b0;
      ext_f        <= 1'b0;
      rel_f        <= 1'b0;
      skip         <= 3'd0;
    end else begin
      key_strobe <= 1'b0;
      if (frame_error) begin
        ext_f <= 1'b0;
        rel_f <= 1'b0;
      end else if (byte_valid) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
          if (skip == 3'd1) begin
            key_code     <= 8'h77;
            key_extended <= 1'b1;
            key_released <= 1'b0;
            key_strobe   <= 1'b1;
          end
        end else if (shift == 8'hE1) begin
          skip <= 3'd7;
        end else if (shift == 8'hE0) begin
          ext_f <= 1'b1;
        end else if (shift == 8'hF0) begin
          rel_f <= 1'b1;
        end else begin
          key_code     <= shift;
          key_extended <= ext_f;
          key_released <= rel_f;
          key_strobe   <= 1'b1;
          ext_f        <= 1'b0;
          rel_f        <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames, scoreboards the emitted key events
// and checks error pulses, timing, timeout, glitch rejection and reset behaviour.
module tb_ps2_kbd_rx;
  localparam int FL   = 4;
  localparam int TO   = 100;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_extended, key_released, key_strobe, frame_error;

  logic [9:0] exp_q[$];
  logic [9:0] exp_v;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int last_fall_cyc = 0;
  int last_strobe_cyc = 0;
  int last_err_cyc = 0;
  int s0, e0;

  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_extended(key_extended), .key_released(key_released),
    .key_strobe(key_strobe), .frame_error(frame_error)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every strobe pops one expected {ext, rel, code}
  always @(negedge clk) begin
    if (key_strobe) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_strobe got=%h expected=none", {key_extended, key_released, key_code});
      end else begin
        exp_v = exp_q.pop_front();
        assert ({key_extended, key_released, key_code} === exp_v) else begin
          fails++;
          $error("FAIL key_event got=%h expected=%h", {key_extended, key_released, key_code}, exp_v);
        end
      end
    end
    if (frame_error) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (key_strobe && frame_error) begin
      tests++;
      fails++;
      $error("FAIL strobe_and_error got=both expected=exclusive");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(stop);
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic push(input logic ext, input logic rel, input logic [7:0] code);
    exp_q.push_back({ext, rel, code});
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("reset_code", key_code, 0);
    check("reset_strobe", key_strobe, 0);
    check("reset_error", frame_error, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Plain make code with strobe latency from the stop-bit pin edge
    s0 = strobe_cnt; e0 = err_cnt;
    push(0, 0, 8'h1C);
    send_frame(8'h1C, 0, 1);
    check("make_1c_count", strobe_cnt - s0, 1);
    check("make_1c_latency", last_strobe_cyc - last_fall_cyc, 2 + FL + 2);
    check("make_1c_no_err", err_cnt - e0, 0);

    // Extended break, then plain make of the same code
    s0 = strobe_cnt;
    push(1, 1, 8'h75);
    send_frame(8'hE0, 0, 1);
    send_frame(8'hF0, 0, 1);
    check("prefix_no_strobe", strobe_cnt - s0, 0);
    send_frame(8'h75, 0, 1);
    push(0, 0, 8'h75);
    send_frame(8'h75, 0, 1);
    check("ext_break_count", strobe_cnt - s0, 2);

    // Parity error, then break
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1, 1);
    check("parity_err_count", err_cnt - e0, 1);
    check("parity_no_strobe", strobe_cnt - s0, 0);
    push(0, 1, 8'h1C);
    send_frame(8'hF0, 0, 1);
    send_frame(8'h1C, 0, 1);

    // Stop-bit error after an E0 must drop the prefix
    e0 = err_cnt;
    send_frame(8'hE0, 0, 1);
    send_frame(8'h44, 0, 0);
    check("stop_err_count", err_cnt - e0, 1);
    push(0, 0, 8'h44);
    send_frame(8'h44, 0, 1);

    // Pause sequence
    s0 = strobe_cnt; e0 = err_cnt;
    push(1, 0, 8'h77);
    send_frame(8'hE1, 0, 1);
    send_frame(8'h14, 0, 1);
    send_frame(8'h77, 0, 1);
    send_frame(8'hE1, 0, 1);
    send_frame(8'hF0, 0, 1);
    send_frame(8'h14, 0, 1);
    send_frame(8'hF0, 0, 1);
    check("pause_mid_no_strobe", strobe_cnt - s0, 0);
    send_frame(8'h77, 0, 1);
    check("pause_count", strobe_cnt - s0, 1);
    check("pause_no_err", err_cnt - e0, 0);

    // Repeated F0 is idempotent; AA passes through as an ordinary code
    push(0, 1, 8'h12);
    send_frame(8'hF0, 0, 1);
    send_frame(8'hF0, 0, 1);
    send_frame(8'h12, 0, 1);
    push(0, 0, 8'hAA);
    send_frame(8'hAA, 0, 1);

    // Timeout mid-frame: start plus 4 data bits, then silence
    e0 = err_cnt; s0 = strobe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    repeat (150) @(negedge clk);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_no_strobe", strobe_cnt - s0, 0);
    check("timeout_not_early", (last_err_cyc - last_fall_cyc) >= TO, 1);
    check("timeout_not_late", (last_err_cyc - last_fall_cyc) <= TO + 10, 1);
    ps2_data = 1'b1;
    push(0, 0, 8'h29);
    send_frame(8'h29, 0, 1);

    // 2-clk glitch with data low must not start a frame
    s0 = strobe_cnt; e0 = err_cnt;
    @(negedge clk);
    ps2_data = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    ps2_data = 1'b1;
    repeat (50) @(negedge clk);
    check("glitch_no_strobe", strobe_cnt - s0, 0);
    check("glitch_no_err", err_cnt - e0, 0);
    push(1, 0, 8'h33);
    send_frame(8'hE0, 0, 1);
    send_frame(8'h33, 0, 1);
    check("glitch_follow_count", strobe_cnt - s0, 1);

    // Reset in the middle of frame 5A
    s0 = strobe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_code", key_code, 0);
    check("rst_ext", key_extended, 0);
    check("rst_rel", key_released, 0);
    check("rst_strobe", key_strobe, 0);
    check("rst_error", frame_error, 0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_strobe", strobe_cnt - s0, 0);
    push(0, 0, 8'h5A);
    send_frame(8'h5A, 0, 1);
    check("rst_follow_count", strobe_cnt - s0, 1);

    repeat (50) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a hang
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Receives the PS/2 keyboard stream generated by user_io (ps2_kbd_clk / ps2_kbd_data) inside the core's system clock domain.
- Deserialises 11-bit frames and checks framing and parity.
- Folds E0 (extended), F0 (break) and E1 (Pause) prefix sequences into single key events for the core's keyboard matrix logic.
- Sits directly downstream of user_io, upstream of the machine-specific key mapper.

Parameters:
- FILTER_LEN, 4: number of consecutive identical synchronised samples needed before the filtered ps2_clk changes state (1..15).
- TIMEOUT_CYCLES, 20000: clk cycles without a filtered falling edge, mid-frame, before the frame is abandoned (≥ 2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ps2_clk  input  1  PS/2 clock from user_io, asynchronous to clk
- ps2_data  input  1  PS/2 data from user_io, asynchronous to clk
- key_code  output  8  scan code of the last completed event
- key_extended  output  1  event was E0-prefixed, or is Pause
- key_released  output  1  event was F0-prefixed (break)
- key_strobe  output  1  one-cycle pulse; key_* outputs are valid while it is high
- frame_error  output  1  one-cycle pulse on parity, stop or timeout error

Behaviour:
- Reset (asynchronous, active-high):
  - key_code = 0, key_extended = 0, key_released = 0, key_strobe = 0, frame_error = 0.
  - Synchronisers and filtered clock are set to 1.
  - FSM returns to IDLE; prefix flags, Pause skip counter and timeout counter are cleared.
  - Reset mid-frame discards the partial frame; nothing is emitted.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Filtered clock changes only after FILTER_LEN consecutive equal synchronised samples.
  - A falling edge is the filtered clock going 1→0. The synchronised data is sampled on that same cycle.
- Frame FSM: IDLE → DATA → PARITY → STOP.
  - IDLE, on falling edge:
    - data = 0 → DATA, bit count = 0, parity accumulator = 0.
    - data = 1 → spurious edge; stay in IDLE, no error.
  - DATA: each edge shifts data in LSB first. After the 8th bit → PARITY.
  - PARITY: the sampled bit is XORed into the accumulator; odd parity is required (accumulator = 1) → STOP.
  - STOP: requires data = 1.
    - Good frame → byte_valid pulses on the next cycle; FSM goes to IDLE.
    - Bad parity or stop = 0 → frame_error pulses on the next cycle; byte discarded; E0/F0 flags cleared; FSM goes to IDLE.
- Timeout:
  - The counter clears on every falling edge and in IDLE; it increments in any other state.
  - Reaching TIMEOUT_CYCLES → frame_error pulse, FSM to IDLE, prefix flags cleared.
  - Timeout and a falling edge in the same cycle: the edge wins and the counter clears.
- Decode (acts on byte_valid):
  - 0xE0 → set ext flag. 0xF0 → set rel flag. Neither emits an event.
  - 0xE1 → load skip = 7; the next 7 valid bytes are swallowed. The 7th swallowed byte emits key_code 0x77, key_extended = 1, key_released = 0.
  - While skip > 0, E0/F0 are not interpreted and the flags are unchanged.
  - Any other byte emits key_code = byte, key_extended = ext, key_released = rel, then clears both flags.
  - Repeated prefixes (E0 E0, F0 F0) are idempotent.
  - 0xAA, 0xFA, 0xEE and 0xFE are emitted as ordinary codes; filtering them is the mapper's job.
- Output timing:
  - key_strobe rises exactly 2 clk after the filtered falling edge of the stop bit, and lasts 1 cycle.
  - key_code, key_extended and key_released hold their value until the next event.
  - key_strobe and frame_error are never high in the same cycle.
- Latency, pin to filtered edge: 2 + FILTER_LEN clk.
- Minimum legal spacing is 2 clk between filtered edges; this is always met because user_io clocks at 12-16 kHz.

Test Plan:
- Frame 0x1C, parity 0, stop 1 → one key_strobe, key_code = 0x1C, ext = 0, rel = 0, 2 clk after the stop edge.
- Sequence E0 F0 75 → one strobe only: code 0x75, ext = 1, rel = 1. A following frame 0x75 → code 0x75, ext = 0, rel = 0.
- Frame 0x1C with parity bit 1 → frame_error pulse, no strobe. A following F0 1C → code 0x1C, rel = 1, ext = 0.
- Sequence E1 14 77 E1 F0 14 F0 77 → exactly one strobe: code 0x77, ext = 1, rel = 0. No error.
- With TIMEOUT_CYCLES = 100: send start bit plus 4 data bits, then idle 150 clk → frame_error at cycle 100 after the last edge. A subsequent full frame 0x29 → code 0x29.
- Glitch and reset:
  - A 2-clk low pulse on ps2_clk with FILTER_LEN = 4 → no bit sampled, no output.
  - reset asserted after the 5th bit of frame 0x5A → all outputs 0 at once. A following full frame 0x5A decodes correctly.
